// File: rtl/booth_mult_radix4_if.sv
// Start/operand/result bundle for the radix-4 Booth multiplier.
// master drives operands and the start pulse; slave is the multiplier side.
interface booth_mult_radix4_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/booth_mult_radix4.sv
// Sequential signed multiplier using radix-4 Booth recoding, 2 multiplier bits per cycle.
// One result per WIDTH/2+1 cycles; a start while busy aborts and restarts.
module booth_mult_radix4 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    booth_mult_radix4_if.slave   bus
);
    localparam int unsigned ITER = WIDTH / 2;
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned MW   = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [MW-1:0]    m_reg, m_n;
    logic [MW-1:0]    h, h_n;
    logic [WIDTH-1:0] l, l_n;
    logic             qm1, qm1_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic             exc_q, exc_n;
    logic             rdy_q, rdy_n;

    logic [MW-1:0]    m2;
    logic [MW-1:0]    pp;
    logic [MW-1:0]    h_sum;
    logic             overflow_c;

    assign m2    = {m_reg[MW-2:0], 1'b0};
    assign h_sum = h + pp;

    // Product {h[WIDTH-1:0], l} overflows when its upper half plus l's sign bit are not uniform
    assign overflow_c = (h[WIDTH-1:0] != {WIDTH{l[WIDTH-1]}});

    // Booth partial product from the current multiplier bit pair and guard bit
    always_comb begin
        pp = '0;
        case ({l[1], l[0], qm1})
            3'b001, 3'b010: pp = m_reg;
            3'b011:         pp = m2;
            3'b100:         pp = MW'(0) - m2;
            3'b101, 3'b110: pp = MW'(0) - m_reg;
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            m_reg    <= '0;
            h        <= '0;
            l        <= '0;
            qm1      <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            m_reg    <= m_n;
            h        <= h_n;
            l        <= l_n;
            qm1      <= qm1_n;
            result_q <= result_n;
            exc_q    <= exc_n;
            rdy_q    <= rdy_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        m_n      = m_reg;
        h_n      = h;
        l_n      = l;
        qm1_n    = qm1;
        result_n = result_q;
        exc_n    = exc_q;
        rdy_n    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.ctrl_MULT) begin
                    state_n = BUSY;
                    cnt_n   = '0;
                    m_n     = {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                    h_n     = '0;
                    l_n     = bus.data_operandB;
                    qm1_n   = 1'b0;
                end
            end
            BUSY: begin
                if (bus.ctrl_MULT) begin
                    state_n = BUSY;
                    cnt_n   = '0;
                    m_n     = {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                    h_n     = '0;
                    l_n     = bus.data_operandB;
                    qm1_n   = 1'b0;
                end else begin
                    // Accumulate then arithmetic-shift {h, l, qm1} right by two
                    h_n   = {{2{h_sum[MW-1]}}, h_sum[MW-1:2]};
                    l_n   = {h_sum[1:0], l[WIDTH-1:2]};
                    qm1_n = l[1];
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                result_n = l;
                exc_n    = overflow_c;
                rdy_n    = 1'b1;
                if (bus.ctrl_MULT) begin
                    state_n = BUSY;
                    cnt_n   = '0;
                    m_n     = {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                    h_n     = '0;
                    l_n     = bus.data_operandB;
                    qm1_n   = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_booth_mult_radix4.sv
// Directed bench for booth_mult_radix4 (WIDTH=32): latency, results, exception,
// abort on restart, reset abort and back-to-back starts on the completion edge.
module tb_booth_mult_radix4;
    logic clock = 1'b0;
    logic reset = 1'b1;

    booth_mult_radix4_if #(.WIDTH(32)) bus ();

    booth_mult_radix4 #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present operands with a start pulse on the next rising edge; scramble operands afterwards
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = 32'h5A5A_A5A5;
        bus.data_operandB = 32'hC3C3_3C3C;
    endtask

    // Called one half-cycle after the start edge: RDY must pulse after exactly 17 more edges
    task automatic expect_done(input string tag, input logic [31:0] r, input logic e);
        int early = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (k < 17 && bus.data_resultRDY === 1'b1) early++;
        end
        check({tag, " early_rdy"}, 64'(early), 64'd0);
        check({tag, " rdy"}, 64'(bus.data_resultRDY), 64'd1);
        check({tag, " result"}, 64'(bus.data_result), 64'(r));
        check({tag, " exception"}, 64'(bus.data_exception), 64'(e));
        @(negedge clock);
        check({tag, " rdy_drop"}, 64'(bus.data_resultRDY), 64'd0);
        check({tag, " result_hold"}, 64'(bus.data_result), 64'(r));
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic e);
        start(a, b);
        expect_done(tag, r, e);
    endtask

    initial begin
        int seen;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset result", 64'(bus.data_result), 64'd0);
        check("reset exception", 64'(bus.data_exception), 64'd0);
        check("reset rdy", 64'(bus.data_resultRDY), 64'd0);

        // Reset wins over a simultaneous start
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd3;
        @(negedge clock);
        reset         = 1'b0;
        bus.ctrl_MULT = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) seen++;
        end
        check("reset_vs_start rdy", 64'(seen), 64'd0);

        do_op("7x-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        do_op("min x -1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        do_op("2^16 x 2^16", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        do_op("max x 1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0);
        do_op("min x 1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        do_op("-1 x -1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op("min x min", 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1);
        do_op("-2^30 x 2", 32'hC000_0000, 32'd2, 32'h8000_0000, 1'b0);
        do_op("46340^2", 32'd46340, 32'd46340, 32'h7FFE_A810, 1'b0);
        do_op("46341^2", 32'd46341, 32'd46341, 32'h8000_1219, 1'b1);
        do_op("ffff^2", 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1);

        // Restart at E8 aborts 5*5; only 6*7 completes, 17 edges after E8
        start(32'd5, 32'd5);
        repeat (6) @(negedge clock);
        start(32'd6, 32'd7);
        expect_done("restart 6x7", 32'd42, 1'b0);

        // Reset at E10 aborts 123*456 and clears the outputs
        start(32'd123, 32'd456);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) seen++;
        end
        check("reset_abort rdy", 64'(seen), 64'd0);
        check("reset_abort result", 64'(bus.data_result), 64'd0);
        check("reset_abort exception", 64'(bus.data_exception), 64'd0);
        do_op("0 x deadbeef", 32'd0, 32'hDEAD_BEEF, 32'd0, 1'b0);

        // Back-to-back: second start lands on the first op's completion edge
        start(32'hFFFF_FFF9, 32'd9);
        repeat (15) @(negedge clock);
        start(32'd1000, 32'hFFFF_FC18);
        check("b2b first rdy", 64'(bus.data_resultRDY), 64'd1);
        check("b2b first result", 64'(bus.data_result), 64'hFFFF_FFC1);
        check("b2b first exception", 64'(bus.data_exception), 64'd0);
        expect_done("b2b second", 32'hFFF0_BDC0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
